// File: rtl/ext_irq_ctrl.sv
// External interrupt front end: synchronises device lines, latches pending bits, and arbitrates by fixed priority.
// Holds a single request towards the core until claim, then blocks new requests until complete.
module ext_irq_ctrl #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b1111,
    parameter int                 ID_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               claim,
    input  logic               complete,
    output logic               External_Intrpt,
    output logic [ID_W-1:0]    claim_id,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] s1, s2, s2_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] rise, clr, sel_vec;
    logic [ID_W-1:0]    lowest_id, id_nxt;
    logic               any_sel, withdrawn;
    logic               ext_nxt, busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            s2_d <= '0;
        end else begin
            s1   <= irq_src;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;

    always_comb begin
        clr = '0;
        if (state == REQ && claim)
            clr[claim_id] = 1'b1;
    end

    // Edge sources: set beats clear in the same cycle. Level sources simply follow the line.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= (EDGE_MASK & ((pending & ~clr) | rise)) | (~EDGE_MASK & s2);
    end

    assign sel_vec   = pending & irq_en;
    assign any_sel   = |sel_vec;
    assign withdrawn = ~(pending[claim_id] & irq_en[claim_id]);

    always_comb begin
        lowest_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (sel_vec[i])
                lowest_id = ID_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        ext_nxt   = External_Intrpt;
        id_nxt    = claim_id;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (any_sel) begin
                    state_nxt = REQ;
                    ext_nxt   = 1'b1;
                    id_nxt    = lowest_id;
                end
            end
            REQ: begin
                if (claim) begin
                    state_nxt = SERVICE;
                    ext_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end else if (withdrawn) begin
                    state_nxt = IDLE;
                    ext_nxt   = 1'b0;
                end
            end
            SERVICE: begin
                if (complete) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ext_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            External_Intrpt <= 1'b0;
            claim_id        <= '0;
            busy            <= 1'b0;
        end else begin
            state           <= state_nxt;
            External_Intrpt <= ext_nxt;
            claim_id        <= id_nxt;
            busy            <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl; source 3 is level sensitive, sources 0..2 edge sensitive.
`timescale 1ns/1ps
module tb_ext_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_src;
    logic [3:0] irq_en;
    logic       claim;
    logic       complete;
    logic       External_Intrpt;
    logic [1:0] claim_id;
    logic       busy;

    int total = 0;
    int bad   = 0;

    ext_irq_ctrl #(
        .NUM_SRC  (4),
        .EDGE_MASK(4'b0111),
        .ID_W     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .irq_en         (irq_en),
        .claim          (claim),
        .complete       (complete),
        .External_Intrpt(External_Intrpt),
        .claim_id       (claim_id),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_src = 4'h0; irq_en = 4'h0; claim = 1'b0; complete = 1'b0;
        tick();
        total++;
        if (External_Intrpt !== 1'b0 || busy !== 1'b0 || claim_id !== 2'd0) begin
            bad++; $display("FAIL reset_out: ext=%b busy=%b id=%0d, want 0 0 0", External_Intrpt, busy, claim_id);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (External_Intrpt !== 1'b0 || busy !== 1'b0 || claim_id !== 2'd0) begin
                bad++; $display("FAIL reset_idle[%0d]: ext=%b busy=%b id=%0d, want 0 0 0", i, External_Intrpt, busy, claim_id);
            end
        end
    endtask

    task automatic test_short_pulse();
        irq_en = 4'hF;
        irq_src = 4'b0001;
        #30;
        irq_src = 4'b0000;
        tick(); tick();
        total++;
        if (External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL pulse_early: ext=%b, want 0", External_Intrpt);
        end
        tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd0) begin
            bad++; $display("FAIL pulse_req: ext=%b id=%0d, want 1 0", External_Intrpt, claim_id);
        end
        tick(); tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd0) begin
            bad++; $display("FAIL pulse_hold: ext=%b id=%0d, want 1 0", External_Intrpt, claim_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        total++;
        if (External_Intrpt !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL pulse_claim: ext=%b busy=%b, want 0 1", External_Intrpt, busy);
        end
        tick();
        complete = 1'b1; tick(); complete = 1'b0;
        total++;
        if (External_Intrpt !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL pulse_complete: ext=%b busy=%b, want 0 0", External_Intrpt, busy);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (External_Intrpt !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL pulse_quiet[%0d]: ext=%b busy=%b, want 0 0", i, External_Intrpt, busy);
            end
        end
    endtask

    task automatic test_priority();
        irq_src = 4'b1010;
        tick(); tick(); tick();
        total++;
        if (External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL prio_early: ext=%b, want 0", External_Intrpt);
        end
        tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd1) begin
            bad++; $display("FAIL prio_first: ext=%b id=%0d, want 1 1", External_Intrpt, claim_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        total++;
        if (busy !== 1'b1 || External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL prio_claim1: busy=%b ext=%b, want 1 0", busy, External_Intrpt);
        end
        claim = 1'b1; complete = 1'b1; tick(); claim = 1'b0; complete = 1'b0;
        total++;
        if (busy !== 1'b0 || External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL prio_both: busy=%b ext=%b, want 0 0", busy, External_Intrpt);
        end
        tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd3) begin
            bad++; $display("FAIL prio_second: ext=%b id=%0d, want 1 3", External_Intrpt, claim_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        total++;
        if (busy !== 1'b1 || External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL prio_claim3: busy=%b ext=%b, want 1 0", busy, External_Intrpt);
        end
        irq_src = 4'b0000;
        tick(); tick(); tick();
        complete = 1'b1; tick(); complete = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL prio_done: busy=%b, want 0", busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (External_Intrpt !== 1'b0) begin
                bad++; $display("FAIL prio_quiet[%0d]: ext=%b, want 0", i, External_Intrpt);
            end
        end
    endtask

    task automatic test_masking();
        irq_en = 4'b1101;
        irq_src = 4'b0010; tick(); irq_src = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (External_Intrpt !== 1'b0) begin
                bad++; $display("FAIL mask_blocked[%0d]: ext=%b, want 0", i, External_Intrpt);
            end
        end
        irq_en = 4'b1111;
        tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd1) begin
            bad++; $display("FAIL mask_enable: ext=%b id=%0d, want 1 1", External_Intrpt, claim_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        complete = 1'b1; tick(); complete = 1'b0;
        total++;
        if (busy !== 1'b0 || External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL mask_done: busy=%b ext=%b, want 0 0", busy, External_Intrpt);
        end
    endtask

    task automatic test_level_withdraw();
        irq_src = 4'b1000;
        tick(); tick(); tick(); tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd3) begin
            bad++; $display("FAIL lvl_req: ext=%b id=%0d, want 1 3", External_Intrpt, claim_id);
        end
        irq_src = 4'b0000;
        tick(); tick(); tick();
        total++;
        if (External_Intrpt !== 1'b1) begin
            bad++; $display("FAIL lvl_still: ext=%b, want 1", External_Intrpt);
        end
        tick();
        total++;
        if (External_Intrpt !== 1'b0 || claim_id !== 2'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL lvl_drop: ext=%b id=%0d busy=%b, want 0 3 0", External_Intrpt, claim_id, busy);
        end
        tick(); tick();
        total++;
        if (External_Intrpt !== 1'b0 || claim_id !== 2'd3) begin
            bad++; $display("FAIL lvl_idle: ext=%b id=%0d, want 0 3", External_Intrpt, claim_id);
        end
    endtask

    task automatic test_rearm_and_reset();
        irq_src = 4'b0100;
        tick(); tick(); tick(); tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd2) begin
            bad++; $display("FAIL rearm_req: ext=%b id=%0d, want 1 2", External_Intrpt, claim_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        irq_src = 4'b0000; tick(); tick();
        irq_src = 4'b0100;
        tick(); tick(); tick(); tick();
        total++;
        if (External_Intrpt !== 1'b0 || busy !== 1'b1 || dut.pending[2] !== 1'b1) begin
            bad++; $display("FAIL rearm_service: ext=%b busy=%b pend2=%b, want 0 1 1", External_Intrpt, busy, dut.pending[2]);
        end
        complete = 1'b1; tick(); complete = 1'b0;
        total++;
        if (External_Intrpt !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rearm_complete: ext=%b busy=%b, want 0 0", External_Intrpt, busy);
        end
        tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd2) begin
            bad++; $display("FAIL rearm_redeliver: ext=%b id=%0d, want 1 2", External_Intrpt, claim_id);
        end
        rst = 1'b1; tick();
        total++;
        if (External_Intrpt !== 1'b0 || busy !== 1'b0 || claim_id !== 2'd0 || dut.pending !== 4'h0) begin
            bad++; $display("FAIL midop_reset: ext=%b busy=%b id=%0d pend=%b, want 0 0 0 0000", External_Intrpt, busy, claim_id, dut.pending);
        end
        rst = 1'b0;
        tick(); tick(); tick();
        total++;
        if (External_Intrpt !== 1'b0) begin
            bad++; $display("FAIL post_reset_early: ext=%b, want 0", External_Intrpt);
        end
        tick();
        total++;
        if (External_Intrpt !== 1'b1 || claim_id !== 2'd2) begin
            bad++; $display("FAIL post_reset_edge: ext=%b id=%0d, want 1 2", External_Intrpt, claim_id);
        end
    endtask

    initial begin
        test_reset();
        test_short_pulse();
        test_priority();
        test_masking();
        test_level_withdraw();
        test_rearm_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
